// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage FSM states and constants
package fetch_pkg;
  typedef enum logic [1:0] {BOOT, REQ, WAIT, FLUSH} fetch_state_e;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [31:0] INSTR_BYTES = 32'd4;
endpackage

// File: rtl/fetch_buf_1e.sv
// fetch_buf_1e: one-entry instr/pc buffer toward decode (in: clk, rst_n, flush_i, load_i, consume_i, instr_i, pc_i; out: valid_o, instr_o = NOP when empty, pc_o)
module fetch_buf_1e
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic        consume_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d, pc_q, pc_d;
  always_comb begin
    valid_d = flush_i ? 1'b0 : load_i ? 1'b1 : consume_i ? 1'b0 : valid_q;
    instr_d = load_i && !flush_i ? instr_i : instr_q;
    pc_d    = load_i && !flush_i ? pc_i : pc_q;
    valid_o = valid_q;
    instr_o = valid_q ? instr_q : NOP_INSTR;
    pc_o    = pc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: IF-stage PC/fetch sequencer (PC reg: pc_cur_i/pc_next_o/pc_stall_o; imem: req/addr/gnt/rvalid/rdata; decode: if_valid/instr/pc/ready; control: redirect_i/redirect_pc_i/trap_i)
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_cur_i,
  output logic [31:0] pc_next_o,
  output logic        pc_stall_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  input  logic        if_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        trap_i
);
  fetch_state_e state_q, state_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         ctl, grant, load, consume;
  assign imem_addr_o = pc_cur_i;
  always_comb begin
    ctl        = (trap_i || redirect_i) && state_q != BOOT;
    consume    = if_valid_o && if_ready_i;
    imem_req_o = state_q == REQ && !ctl && (!if_valid_o || if_ready_i);
    grant      = imem_req_o && imem_gnt_i;
    load       = state_q == WAIT && imem_rvalid_i && !ctl;
    pc_stall_o = !(ctl || grant);
    pc_next_o  = state_q == BOOT ? RESET_VECTOR :
                 trap_i ? TRAP_VECTOR :
                 redirect_i ? {redirect_pc_i[31:2], 2'b00} : pc_cur_i + INSTR_BYTES;
    req_pc_d   = grant ? pc_cur_i : req_pc_q;
    state_d    = state_q;
    case (state_q)
      BOOT:    state_d = REQ;
      REQ:     state_d = grant ? WAIT : REQ;
      WAIT:    state_d = imem_rvalid_i ? REQ : ctl ? FLUSH : WAIT;
      FLUSH:   state_d = imem_rvalid_i ? REQ : FLUSH;
      default: state_d = BOOT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end
  fetch_buf_1e u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (ctl),
    .load_i   (load),
    .consume_i(consume),
    .instr_i  (imem_rdata_i),
    .pc_i     (req_pc_q),
    .valid_o  (if_valid_o),
    .instr_o  (if_instr_o),
    .pc_o     (if_pc_o)
  );
endmodule
